// File: rtl/ccm_pkg.sv
// Shared constants and address helpers for the banked closely-coupled memory.
// Bank/row/error decoding lives here so the arbiter and the bench agree on one definition.
package ccm_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    // Starve counter width; never below one bit.
    function automatic int unsigned starve_w(input int unsigned smax);
        return (smax < 1) ? 1 : $clog2(smax + 1);
    endfunction

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

    // Word-interleaved: low word-index bits pick the bank, the rest pick the row.
    function automatic logic [29:0] bank_of(input logic [31:0] addr, input int unsigned nbanks);
        return word_index(addr) & 30'(nbanks - 1);
    endfunction

    function automatic logic [29:0] row_of(input logic [31:0] addr, input int unsigned bank_bits);
        return word_index(addr) >> bank_bits;
    endfunction

    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/ccm_bank.sv
// Single-port synchronous RAM bank with byte-enable writes and a 1-cycle read.
// Contents are deliberately not reset; rdata only changes on an enabled read.
module ccm_bank
    import ccm_pkg::*;
#(
    parameter int ROWS  = 2048,
    parameter int ROW_W = 11
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (be[k]) begin
                        mem[row][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end else begin
                rdata <= mem[row];
            end
        end
    end

endmodule

// File: rtl/ccm_banked_arb.sv
// Banked CCM shared by instruction fetch (I) and data (D) ports, with per-bank
// arbitration: D wins same-bank conflicts unless I has lost STARVE_MAX in a row.
//
// Handshake: a request transfers in a cycle where valid and ready are both 1.
// ready depends combinationally on both ports' valids and addresses; a port
// with valid=1 and ready=0 holds its request stable. Responses arrive exactly
// one cycle after acceptance and cannot be back-pressured.
module ccm_banked_arb #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int NBANKS      = 2,
    parameter int STARVE_MAX  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req_valid,
    output logic                     i_req_ready,
    input  logic [31:0]              i_req_addr,
    output logic                     i_rsp_valid,
    output logic [DATA_W-1:0]        i_rsp_data,
    output logic                     i_rsp_err,
    input  logic                     d_req_valid,
    output logic                     d_req_ready,
    input  logic                     d_req_we,
    input  logic [ccm_pkg::BE_W-1:0] d_req_be,
    input  logic [31:0]              d_req_addr,
    input  logic [DATA_W-1:0]        d_req_wdata,
    output logic                     d_rsp_valid,
    output logic [DATA_W-1:0]        d_rsp_data,
    output logic                     d_rsp_err
);
    import ccm_pkg::*;

    localparam int BANK_BITS = $clog2(NBANKS);
    localparam int BANK_W    = (NBANKS > 1) ? BANK_BITS : 1;
    localparam int ROWS      = DEPTH_WORDS / NBANKS;
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW        = starve_w(STARVE_MAX);

    logic              i_err, d_err;
    logic [BANK_W-1:0] i_bank, d_bank;
    logic [ROW_W-1:0]  i_row, d_row;
    logic              conflict, i_pri;
    logic              i_acc, d_acc, i_go, d_go;
    logic [SW-1:0]     starve_cnt;

    assign i_err  = addr_err(i_req_addr, DEPTH_WORDS);
    assign d_err  = addr_err(d_req_addr, DEPTH_WORDS);
    assign i_bank = BANK_W'(bank_of(i_req_addr, NBANKS));
    assign d_bank = BANK_W'(bank_of(d_req_addr, NBANKS));
    assign i_row  = ROW_W'(row_of(i_req_addr, BANK_BITS));
    assign d_row  = ROW_W'(row_of(d_req_addr, BANK_BITS));

    // Errored requests never reach a bank, so they can never conflict.
    assign conflict = i_req_valid && !i_err && d_req_valid && !d_err && (i_bank == d_bank);
    assign i_pri    = (starve_cnt == SW'(STARVE_MAX));

    assign i_req_ready = !rst && !(conflict && !i_pri);
    assign d_req_ready = !rst && !(conflict && i_pri);

    assign i_acc = i_req_valid && i_req_ready;
    assign d_acc = d_req_valid && d_req_ready;
    assign i_go  = i_acc && !i_err;
    assign d_go  = d_acc && !d_err;

    logic [DATA_W-1:0] bank_rdata [NBANKS];

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic             i_hit, d_hit;
        logic [ROW_W-1:0] row_sel;

        assign i_hit   = i_go && (i_bank == BANK_W'(b));
        assign d_hit   = d_go && (d_bank == BANK_W'(b));
        assign row_sel = d_hit ? d_row : i_row;

        ccm_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk   (clk),
            .en    (i_hit || d_hit),
            .we    (d_hit && d_req_we),
            .be    (d_req_be),
            .row   (row_sel),
            .wdata (d_req_wdata),
            .rdata (bank_rdata[b])
        );
    end

    logic              i_vq, i_eq, d_vq, d_eq, d_wq;
    logic [BANK_W-1:0] i_bq, d_bq;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_vq       <= 1'b0;
            i_eq       <= 1'b0;
            i_bq       <= '0;
            d_vq       <= 1'b0;
            d_eq       <= 1'b0;
            d_wq       <= 1'b0;
            d_bq       <= '0;
            starve_cnt <= '0;
        end else begin
            i_vq <= i_acc;
            i_eq <= i_acc && i_err;
            i_bq <= i_bank;
            d_vq <= d_acc;
            d_eq <= d_acc && d_err;
            d_wq <= d_acc && d_req_we;
            d_bq <= d_bank;
            if (i_acc) begin
                starve_cnt <= '0;
            end else if (conflict && !i_pri) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Gating with rst kills a response that falls due in a reset cycle.
    assign i_rsp_valid = i_vq && !rst;
    assign i_rsp_err   = i_rsp_valid && i_eq;
    assign i_rsp_data  = (i_rsp_valid && !i_eq) ? bank_rdata[i_bq] : '0;

    assign d_rsp_valid = d_vq && !rst;
    assign d_rsp_err   = d_rsp_valid && d_eq;
    assign d_rsp_data  = (d_rsp_valid && !d_eq && !d_wq) ? bank_rdata[d_bq] : '0;

endmodule

// File: tb/tb_ccm_banked_arb.sv
// Directed bench for ccm_banked_arb: expected responses are queued at acceptance
// and matched by a negedge monitor against a bench-side memory model.
module tb_ccm_banked_arb;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
    logic [3:0]  d_req_be;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [31:0] model [0:DEPTH-1];
    logic [63:0] i_exp_q[$];
    logic [63:0] d_exp_q[$];
    logic [63:0] ie, de;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ccm_banked_arb #(
        .DATA_W      (32),
        .DEPTH_WORDS (DEPTH),
        .NBANKS      (2),
        .STARVE_MAX  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_ready (i_req_ready),
        .i_req_addr  (i_req_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_data  (i_rsp_data),
        .i_rsp_err   (i_rsp_err),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_req_we    (d_req_we),
        .d_req_be    (d_req_be),
        .d_req_addr  (d_req_addr),
        .d_req_wdata (d_req_wdata),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_err   (d_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // {err, data} the bench expects for an access at addr.
    function automatic logic [32:0] expect_rsp(input logic [31:0] addr, input logic is_write);
        logic err;
        err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
        if (err || is_write) return {err, 32'h0};
        return {1'b0, model[addr[13:2]]};
    endfunction

    task automatic step(input logic iv, input logic [31:0] ia,
                        input logic dv, input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input logic exp_ir, input logic exp_dr, input string tag);
        logic [32:0] r;
        @(posedge clk);
        #1;
        i_req_valid = iv;
        i_req_addr  = ia;
        d_req_valid = dv;
        d_req_we    = dwe;
        d_req_be    = dbe;
        d_req_addr  = da;
        d_req_wdata = dwd;
        @(negedge clk);
        if (iv) chk({tag, "_i_ready"}, {31'h0, i_req_ready}, {31'h0, exp_ir});
        if (dv) chk({tag, "_d_ready"}, {31'h0, d_req_ready}, {31'h0, exp_dr});
        if (iv && exp_ir) begin
            r = expect_rsp(ia, 1'b0);
            i_exp_q.push_back({31'(cyc + 1), r});
        end
        if (dv && exp_dr) begin
            r = expect_rsp(da, dwe);
            d_exp_q.push_back({31'(cyc + 1), r});
            if (dwe && !r[32]) begin
                for (int k = 0; k < 4; k++) begin
                    if (dbe[k]) model[da[13:2]][8*k +: 8] = dwd[8*k +: 8];
                end
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, "idle");
    endtask

    // One reset cycle with both ports hammering; the D write must be dropped.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0;
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_be    = 4'hF;
        d_req_addr  = 32'h4;
        d_req_wdata = 32'hDEADBEEF;
        i_exp_q.delete();
        d_exp_q.delete();
        @(negedge clk);
        chk("rst_i_ready", {31'h0, i_req_ready}, 32'h0);
        chk("rst_d_ready", {31'h0, d_req_ready}, 32'h0);
        chk("rst_i_rsp_valid", {31'h0, i_rsp_valid}, 32'h0);
        chk("rst_d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_i_valid", {31'h0, i_rsp_valid}, 32'h0);
        chk("post_rst_d_valid", {31'h0, d_rsp_valid}, 32'h0);
        chk("post_rst_i_data", i_rsp_data, 32'h0);
        chk("post_rst_d_data", d_rsp_data, 32'h0);
        chk("post_rst_i_err", {31'h0, i_rsp_err}, 32'h0);
        chk("post_rst_d_err", {31'h0, d_rsp_err}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (i_rsp_valid === 1'b1) begin
            if (i_exp_q.size() == 0) begin
                chk("i_rsp_unexpected", 32'h1, 32'h0);
            end else begin
                ie = i_exp_q.pop_front();
                chk("i_rsp_due", 32'(cyc), {1'b0, ie[63:33]});
                chk("i_rsp_err", {31'h0, i_rsp_err}, {31'h0, ie[32]});
                chk("i_rsp_data", i_rsp_data, ie[31:0]);
            end
        end else if (i_exp_q.size() != 0 && i_exp_q[0][63:33] <= 31'(cyc)) begin
            ie = i_exp_q.pop_front();
            chk("i_rsp_missing", {31'h0, i_rsp_valid}, 32'h1);
        end
        if (d_rsp_valid === 1'b1) begin
            if (d_exp_q.size() == 0) begin
                chk("d_rsp_unexpected", 32'h1, 32'h0);
            end else begin
                de = d_exp_q.pop_front();
                chk("d_rsp_due", 32'(cyc), {1'b0, de[63:33]});
                chk("d_rsp_err", {31'h0, d_rsp_err}, {31'h0, de[32]});
                chk("d_rsp_data", d_rsp_data, de[31:0]);
            end
        end else if (d_exp_q.size() != 0 && d_exp_q[0][63:33] <= 31'(cyc)) begin
            de = d_exp_q.pop_front();
            chk("d_rsp_missing", {31'h0, d_rsp_valid}, 32'h1);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        i_req_valid = 1'b0;
        i_req_addr  = 32'h0;
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_be    = 4'h0;
        d_req_addr  = 32'h0;
        d_req_wdata = 32'h0;

        do_reset();

        // Preload through the D port.
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0000, 32'h1000_0001, 1'b0, 1'b1, "pre0");
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0004, 32'h2000_0002, 1'b0, 1'b1, "pre4");
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0008, 32'h3000_0003, 1'b0, 1'b1, "pre8");
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0010, 32'h1122_3344, 1'b0, 1'b1, "pre10");
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h3FFC, 32'h5555_AAAA, 1'b0, 1'b1, "pre3ffc");

        // Different banks granted together, back to back.
        step(1'b1, 32'h0000, 1'b1, 1'b0, 4'h0, 32'h0004, 32'h0, 1'b1, 1'b1, "par0");
        step(1'b1, 32'h0004, 1'b1, 1'b0, 4'h0, 32'h0000, 32'h0, 1'b1, 1'b1, "par1");
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h3FFC, 32'h0, 1'b1, 1'b1, "par2");

        // Same-bank conflict: D, D, D, I, D.
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0, 1'b0, 1'b1, "cf1");
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0, 1'b0, 1'b1, "cf2");
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0, 1'b0, 1'b1, "cf3");
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0, 1'b1, 1'b0, "cf4");
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0, 1'b0, 1'b1, "cf5");
        step(1'b1, 32'h0008, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, "cf6");

        // Byte enables, then an all-zero enable no-op.
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h0010, 32'hAABB_CCDD, 1'b0, 1'b1, "be_wr");
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0010, 32'h0, 1'b0, 1'b1, "be_rd");
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h0010, 32'hFFFF_FFFF, 1'b0, 1'b1, "be0_wr");
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0010, 32'h0, 1'b0, 1'b1, "be0_rd");

        // Errors: accepted alongside a same-bank partner, never a conflict.
        step(1'b1, 32'h0000, 1'b1, 1'b0, 4'h0, 32'h0002, 32'h0, 1'b1, 1'b1, "err_d_mis");
        step(1'b1, 32'h4000, 1'b1, 1'b0, 4'h0, 32'h0000, 32'h0, 1'b1, 1'b1, "err_i_oor");
        step(1'b1, 32'h3FFC, 1'b1, 1'b1, 4'hF, 32'h0002, 32'hFFFF_FFFF, 1'b1, 1'b1, "err_d_wr");
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000, 32'h0, 1'b0, 1'b1, "err_chk0");

        // Reset mid-operation with the starve counter saturated.
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0, 1'b0, 1'b1, "sv1");
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0, 1'b0, 1'b1, "sv2");
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0, 1'b0, 1'b1, "sv3");
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000, 32'h0, 1'b0, 1'b1, "mid_rd");
        do_reset();
        step(1'b1, 32'h0008, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0, 1'b0, 1'b1, "post_cf");
        step(1'b1, 32'h0008, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, "post_i");
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0004, 32'h0, 1'b0, 1'b1, "post_rd4");
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000, 32'h0, 1'b0, 1'b1, "post_rd0");

        // Write then read the same word on consecutive cycles.
        step(1'b1, 32'h0004, 1'b1, 1'b1, 4'hF, 32'h0020, 32'hCAFE_F00D, 1'b1, 1'b1, "wr20");
        step(1'b1, 32'h0004, 1'b1, 1'b0, 4'h0, 32'h0020, 32'h0, 1'b1, 1'b1, "rd20");
        step(1'b1, 32'h0020, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, "i_rd20");

        // Random same-bank-free traffic: I on even words, D reads odd words.
        for (int n = 0; n < 8; n++) begin
            step(1'b1, 32'h0 | (32'($urandom_range(0, 1)) << 3),
                 1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 1'b1, "rnd");
        end

        idle();
        idle();
        idle();
        chk("i_queue_drained", 32'(i_exp_q.size()), 32'h0);
        chk("d_queue_drained", 32'(d_exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
